// File: rtl/boot_mem_responder.sv
// Boot-time memory responder for a 6502 bus: a byte-stream loader fills RAM and the
// reset vectors while the CPU is held in reset, then the CPU owns the bus.
module boot_mem_responder #(
  parameter int          MEM_AW    = 12,
  parameter logic [15:0] RESET_VEC = 16'h0200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        cpu_resetn,
  input  logic [15:0] address,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    ADDR_LO = 3'd0,
    ADDR_HI = 3'd1,
    LEN_LO  = 3'd2,
    LEN_HI  = 3'd3,
    DATA    = 3'd4,
    RUN     = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_s;
  logic        ld_ready_s;
  logic        accept_s;
  logic        cpu_resetn_r;
  logic [15:0] ld_addr_r;
  logic [15:0] ld_len_r;
  logic [7:0]  vec_lo_r;
  logic [7:0]  vec_hi_r;
  logic [7:0]  rd_data_r;
  logic        ld_we_s;
  logic        cpu_we_s;
  logic        we_s;
  logic [15:0] waddr_s;
  logic [7:0]  wdata_s;
  logic [7:0]  mem [0:DEPTH-1];

  assign accept_s   = ld_valid & ld_ready_s;
  assign ld_ready   = ld_ready_s;
  assign cpu_resetn = cpu_resetn_r;
  assign rd_data    = rd_data_r;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ADDR_LO;
    else         state_r <= next_s;
  end

  // Next-state logic: one accepted byte per transition
  always_comb begin
    next_s = state_r;
    case (state_r)
      ADDR_LO: if (accept_s) next_s = ADDR_HI; else next_s = state_r;
      ADDR_HI: if (accept_s) next_s = LEN_LO;  else next_s = state_r;
      LEN_LO:  if (accept_s) next_s = LEN_HI;  else next_s = state_r;
      LEN_HI: begin
        if (accept_s) next_s = ({ld_data, ld_len_r[7:0]} == 16'h0000) ? RUN : DATA;
        else          next_s = state_r;
      end
      DATA: begin
        if (accept_s && (ld_len_r == 16'h0001)) next_s = RUN;
        else                                     next_s = state_r;
      end
      RUN:     next_s = RUN;
      default: next_s = ADDR_LO;
    endcase
  end

  // Output decode from state
  always_comb begin
    ld_ready_s = 1'b1;
    case (state_r)
      RUN:     ld_ready_s = 1'b0;
      default: ld_ready_s = 1'b1;
    endcase
  end

  // CPU reset release coincides with the edge that enters RUN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cpu_resetn_r <= 1'b0;
    else         cpu_resetn_r <= (next_s == RUN);
  end

  // Header capture and load pointer/length bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_addr_r <= 16'h0000;
      ld_len_r  <= 16'h0000;
    end else if (accept_s) begin
      case (state_r)
        ADDR_LO: ld_addr_r[7:0]  <= ld_data;
        ADDR_HI: ld_addr_r[15:8] <= ld_data;
        LEN_LO:  ld_len_r[7:0]   <= ld_data;
        LEN_HI:  ld_len_r[15:8]  <= ld_data;
        DATA: begin
          ld_addr_r <= ld_addr_r + 16'h0001;
          ld_len_r  <= ld_len_r - 16'h0001;
        end
        default: ld_addr_r <= ld_addr_r;
      endcase
    end
  end

  // Single write port shared by loader (DATA) and CPU (RUN); they never overlap
  always_comb begin
    ld_we_s  = accept_s && (state_r == DATA);
    cpu_we_s = wr_en && (state_r == RUN);
    we_s     = ld_we_s | cpu_we_s;
    if (ld_we_s) begin
      waddr_s = ld_addr_r;
      wdata_s = ld_data;
    end else begin
      waddr_s = address;
      wdata_s = wr_data;
    end
  end

  // Reset vector registers decoded on the full 16-bit address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vec_lo_r <= RESET_VEC[7:0];
      vec_hi_r <= RESET_VEC[15:8];
    end else if (we_s && (waddr_s == 16'hFFFC)) begin
      vec_lo_r <= wdata_s;
    end else if (we_s && (waddr_s == 16'hFFFD)) begin
      vec_hi_r <= wdata_s;
    end
  end

  // RAM array, aliased on the low MEM_AW bits and deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s && (waddr_s != 16'hFFFC) && (waddr_s != 16'hFFFD))
      mem[waddr_s[MEM_AW-1:0]] <= wdata_s;
  end

  // Registered read; nonblocking update gives read-before-write on collisions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_r <= 8'h00;
    end else begin
      case (address)
        16'hFFFC: rd_data_r <= vec_lo_r;
        16'hFFFD: rd_data_r <= vec_hi_r;
        default:  rd_data_r <= mem[address[MEM_AW-1:0]];
      endcase
    end
  end

endmodule
